vga_capture: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_sync_tracker.sv | 137 +++++++++++++
 rtl/vga_capture.sv | 161 ++++++++++++++++
 tb/tb_vga_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 VGA timing constants and the receive-side
//               lock state type. Imported by the display and capture blocks.
// Contents    : H_/V_ timing localparams, lock_state_e, is_pow2() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 timing, counted in pixel samples / lines from the sync edge
  localparam int H_TOTAL        = 800;
  localparam int H_ACTIVE_BEGIN = 143;
  localparam int H_ACTIVE_LEN   = 640;
  localparam int V_TOTAL        = 525;
  localparam int V_ACTIVE_BEGIN = 34;
  localparam int V_ACTIVE_LEN   = 480;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  // Lets the decimator pick shift/mask arithmetic over a divider
  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_tracker.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_tracker
// Description : Registers the incoming VGA sync/colour stream, recovers the
//               pixel (h) and line (v) position of the sample currently held,
//               and verifies line/frame length with a three-state lock FSM.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               pix_en                - pixel-rate enable
//               hsync, vsync, rgb     - raw VGA inputs (syncs active low)
//               h, v                  - position of the held sample
//               rgb_s                 - colour of the held sample
//               frame_start           - one-cycle frame start event
//               err                   - one-cycle line/frame check failure
//               locked                - timing verified
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_tracker #(
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic [2:0] rgb_s,
  output logic       frame_start,
  output logic       err,
  output logic       locked
);
  import vga_pkg::*;

  localparam logic [9:0] c_h_last  = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last  = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_cnt_max = 10'd1023;

  // Stage S holds the latest sample; it is also the "previous" value that
  // the incoming sample is compared against, so h/v always describe the
  // pixel currently in S and the colour and position stay aligned.
  logic        hs_q,    hs_d;
  logic        vs_q,    vs_d;
  logic [2:0]  rgb_q,   rgb_d;
  logic        vpend_q, vpend_d;
  logic [9:0]  h_q,     h_d;
  logic [9:0]  v_q,     v_d;
  lock_state_e state_q, state_d;

  logic w_hfall;
  logic w_vfall;
  logic w_fs;
  logic w_line_bad;
  logic w_frame_bad;
  logic w_chk_fail;

  always_comb begin
    hs_d    = hs_q;
    vs_d    = vs_q;
    rgb_d   = rgb_q;
    vpend_d = vpend_q;
    h_d     = h_q;
    v_d     = v_q;
    state_d = state_q;

    w_hfall = hs_q & ~hsync;
    w_vfall = vs_q & ~vsync;
    // vsync may fall anywhere in a line; the frame starts on the next hsync
    // edge, so a vsync edge is held pending until that edge arrives.
    w_fs        = w_hfall & (vpend_q | w_vfall);
    w_line_bad  = w_hfall & (h_q != c_h_last);
    w_frame_bad = w_fs & (v_q != c_v_last);
    w_chk_fail  = (state_q != UNLOCKED) & (w_line_bad | w_frame_bad);

    if (pix_en) begin
      hs_d  = hsync;
      vs_d  = vsync;
      rgb_d = rgb;

      if (w_hfall) begin
        h_d     = '0;
        vpend_d = 1'b0;
        if (w_fs) begin
          v_d = '0;
        end else if (v_q != c_cnt_max) begin
          v_d = v_q + 10'd1;
        end
      end else begin
        vpend_d = vpend_q | w_vfall;
        if (h_q != c_cnt_max) begin
          h_d = h_q + 10'd1;
        end
      end

      if (w_chk_fail) begin
        state_d = UNLOCKED;
      end else if (w_fs) begin
        unique case (state_q)
          UNLOCKED: state_d = ARMED;
          ARMED:    state_d = LOCKED;
          LOCKED:   state_d = LOCKED;
          default:  state_d = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
      vpend_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      state_q <= UNLOCKED;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      vpend_q <= vpend_d;
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
    end
  end

  assign h           = h_q;
  assign v           = v_q;
  assign rgb_s       = rgb_q;
  assign frame_start = pix_en & w_fs;
  assign err         = pix_en & w_chk_fail;
  assign locked      = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : vga_capture
// Description : VGA receiver for display loopback / external capture. Tracks
//               the incoming timing, decimates each BLK x BLK screen block to
//               its centre sample and writes it to a framebuffer port.
// Ports       : clock, reset     - clock, synchronous active-high reset
//               pix_en           - pixel-rate enable
//               hsync, vsync     - active-low syncs
//               rgb              - 3-bit pixel colour
//               wr_en            - one-cycle framebuffer write strobe
//               wr_addr, wr_data - framebuffer address (fb_y*FB_W+fb_x)/colour
//               locked           - timing verified, writes enabled
//               frame_done       - one-cycle pulse per good frame
//               sync_err         - one-cycle pulse per timing violation
// Revision    : 1.0 - initial release
// ============================================================================
module vga_capture #(
  parameter  int PIXEL_SCALING_FACTOR = 8,
  parameter  int H_TOTAL        = vga_pkg::H_TOTAL,
  parameter  int H_ACTIVE_BEGIN = vga_pkg::H_ACTIVE_BEGIN,
  parameter  int H_ACTIVE_LEN   = vga_pkg::H_ACTIVE_LEN,
  parameter  int V_TOTAL        = vga_pkg::V_TOTAL,
  parameter  int V_ACTIVE_BEGIN = vga_pkg::V_ACTIVE_BEGIN,
  parameter  int V_ACTIVE_LEN   = vga_pkg::V_ACTIVE_LEN,
  localparam int BLK   = 2 * PIXEL_SCALING_FACTOR,
  localparam int FB_W  = H_ACTIVE_LEN / BLK,
  localparam int FB_H  = V_ACTIVE_LEN / BLK,
  localparam int FB_AW = $clog2(FB_W * FB_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [2:0]       rgb,
  output logic             wr_en,
  output logic [FB_AW-1:0] wr_addr,
  output logic [2:0]       wr_data,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);
  import vga_pkg::*;

  localparam logic [9:0] c_h_beg = 10'(H_ACTIVE_BEGIN);
  localparam logic [9:0] c_h_end = 10'(H_ACTIVE_BEGIN + H_ACTIVE_LEN - 1);
  localparam logic [9:0] c_v_beg = 10'(V_ACTIVE_BEGIN);
  localparam logic [9:0] c_v_end = 10'(V_ACTIVE_BEGIN + V_ACTIVE_LEN - 1);

  logic [9:0] w_h;
  logic [9:0] w_v;
  logic [2:0] w_rgb_s;
  logic       w_frame_start;
  logic       w_err;
  logic       w_locked;

  vga_sync_tracker #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .h           (w_h),
    .v           (w_v),
    .rgb_s       (w_rgb_s),
    .frame_start (w_frame_start),
    .err         (w_err),
    .locked      (w_locked)
  );

  // Marks the single cycle after a pix_en in which stage S holds a fresh
  // sample, so a sample point produces exactly one write however widely
  // pix_en pulses are spaced.
  logic fresh_q, fresh_d;

  logic [9:0]  w_xo;
  logic [9:0]  w_yo;
  logic [9:0]  w_fb_x;
  logic [9:0]  w_fb_y;
  logic        w_on_x;
  logic        w_on_y;
  logic        w_active;
  logic        w_hit;
  logic [15:0] w_addr_full;

  assign w_xo     = w_h - c_h_beg;
  assign w_yo     = w_v - c_v_beg;
  assign w_active = (w_h >= c_h_beg) && (w_h <= c_h_end) &&
                    (w_v >= c_v_beg) && (w_v <= c_v_end);

  if (is_pow2(BLK)) begin : g_pow2
    localparam int SH = $clog2(BLK);
    assign w_fb_x = w_xo >> SH;
    assign w_fb_y = w_yo >> SH;
    assign w_on_x = (w_xo & 10'(BLK - 1)) == 10'(BLK / 2);
    assign w_on_y = (w_yo & 10'(BLK - 1)) == 10'(BLK / 2);
  end else begin : g_div
    assign w_fb_x = w_xo / 10'(BLK);
    assign w_fb_y = w_yo / 10'(BLK);
    assign w_on_x = (w_xo % 10'(BLK)) == 10'(BLK / 2);
    assign w_on_y = (w_yo % 10'(BLK)) == 10'(BLK / 2);
  end

  // Sample points only exist inside the active area, so the product always
  // fits FB_AW bits; the 16-bit intermediate avoids overflow in the multiply.
  assign w_addr_full = 16'(w_fb_y) * 16'(FB_W) + 16'(w_fb_x);
  assign w_hit       = fresh_q & w_locked & w_active & w_on_x & w_on_y;

  logic             wr_en_q,      wr_en_d;
  logic [FB_AW-1:0] wr_addr_q,    wr_addr_d;
  logic [2:0]       wr_data_q,    wr_data_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q,   sync_err_d;

  always_comb begin
    fresh_d      = pix_en;
    wr_en_d      = w_hit;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    // w_locked is still the pre-event state here: a good frame start seen
    // while already locked closes a good frame.
    frame_done_d = w_frame_start & ~w_err & w_locked;
    sync_err_d   = w_err;
    if (w_hit) begin
      wr_addr_d = FB_AW'(w_addr_full);
      wr_data_d = w_rgb_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fresh_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      fresh_q      <= fresh_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign locked     = w_locked;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_capture
// Description : Self-checking bench for vga_capture on a reduced raster
//               (40x30 total, 16x16 active, 4x4 blocks -> 4x4 framebuffer).
//               Expected writes (address, colour, arrival cycle) are queued
//               as pixels are driven and matched against the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

  localparam int SCALE = 2;
  localparam int HT    = 40;
  localparam int HB    = 10;
  localparam int HL    = 16;
  localparam int VT    = 30;
  localparam int VB    = 4;
  localparam int VL    = 16;
  localparam int BLK   = 2 * SCALE;
  localparam int FBW   = HL / BLK;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic [2:0]    rgb;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          locked;
  logic          frame_done;
  logic          sync_err;

  vga_capture #(
    .PIXEL_SCALING_FACTOR (SCALE),
    .H_TOTAL              (HT),
    .H_ACTIVE_BEGIN       (HB),
    .H_ACTIVE_LEN         (HL),
    .V_TOTAL              (VT),
    .V_ACTIVE_BEGIN       (VB),
    .V_ACTIVE_LEN         (VL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [2:0]    d;
    int            t;
  } wr_t;

  wr_t sb[$];
  wr_t got;

  int checks   = 0;
  int failures = 0;
  int n_wr     = 0;
  int n_fd     = 0;
  int n_se     = 0;
  bit exp_locked = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Write-port monitor and pulse counters, sampled away from the clock edge
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      n_wr++;
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(got.a));
        check("wr_data", 32'(wr_data), 32'(got.d));
        check("wr_cycle", 32'(cyc), 32'(got.t));
      end
    end
    if (frame_done === 1'b1) n_fd++;
    if (sync_err === 1'b1) n_se++;
  end

  // One VGA pixel: pix_en for one clock, then one idle clock
  task automatic pix(input logic hs, input logic vs, input logic [2:0] c,
                     input int h, input int v);
    wr_t e;
    pix_en = 1'b1;
    hsync  = hs;
    vsync  = vs;
    rgb    = c;
    if (exp_locked && h >= HB && h < HB + HL && v >= VB && v < VB + VL &&
        ((h - HB) % BLK) == BLK / 2 && ((v - VB) % BLK) == BLK / 2) begin
      e.a = AW'(((v - VB) / BLK) * FBW + (h - HB) / BLK);
      e.d = c;
      e.t = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    pix_en = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, "_wr_data"},    32'(wr_data),    32'd0);
    check({tag, "_locked"},     32'(locked),     32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_sync_err"},   32'(sync_err),   32'd0);
  endtask

  // One frame. mode: 0 fixed 5, 1 (h>>2)&7, 2 random. A line index of -1
  // disables the shortened line / reset / pix_en pause events.
  task automatic frame(input int nlines, input int mode, input bit lk,
                       input int short_line, input int rst_line,
                       input int pause_line, input int exp_w, input string tag);
    int w0;
    int se0;
    int len;
    logic [2:0] c;
    w0 = n_wr;
    exp_locked = lk;
    for (int v = 0; v < nlines; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        case (mode)
          0:       c = 3'd5;
          1:       c = 3'((h >> 2) & 7);
          default: c = 3'($urandom_range(7));
        endcase
        pix((h < 4) ? 1'b0 : 1'b1, (v < 2) ? 1'b0 : 1'b1, c, h, v);
        if (v == rst_line && h == 15) begin
          reset = 1'b1;
          @(posedge clock); #1;
          reset = 1'b0;
          exp_locked = 1'b0;
          check_outputs_zero({tag, "_midrst"});
        end
        if (v == pause_line && h == 12) begin
          se0 = n_se;
          repeat (100) @(posedge clock);
          #1;
          check({tag, "_pause_no_err"}, 32'(n_se), 32'(se0));
          check({tag, "_pause_locked"}, 32'(locked), 32'd1);
        end
      end
      if (v == short_line) exp_locked = 1'b0;
    end
    check({tag, "_writes"}, 32'(n_wr - w0), 32'(exp_w));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    rgb    = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // First frame start arms only; second one locks
    frame(VT, 0, 1'b0, -1, -1, -1, 0, "A");
    check("A_locked", 32'(locked), 32'd0);
    frame(VT, 0, 1'b1, -1, -1, -1, 16, "B");
    check("B_locked", 32'(locked), 32'd1);
    check("B_frame_done", 32'(n_fd), 32'd0);
    frame(VT, 1, 1'b1, -1, -1, -1, 16, "C");
    check("C_frame_done", 32'(n_fd), 32'd1);
    frame(VT, 2, 1'b1, -1, -1, -1, 16, "D");
    check("D_frame_done", 32'(n_fd), 32'd2);

    // Short line: error on the following hsync edge, relock two starts later
    frame(VT, 0, 1'b1, 10, -1, -1, 8, "E");
    check("E_sync_err", 32'(n_se), 32'd1);
    check("E_locked", 32'(locked), 32'd0);
    check("E_frame_done", 32'(n_fd), 32'd3);
    frame(VT, 0, 1'b0, -1, -1, -1, 0, "F");
    check("F_locked", 32'(locked), 32'd0);
    frame(VT, 2, 1'b1, -1, -1, -1, 16, "G");
    check("G_locked", 32'(locked), 32'd1);
    check("G_frame_done", 32'(n_fd), 32'd3);

    // Frame one line short: error at the next frame start, no frame_done
    frame(VT - 1, 2, 1'b1, -1, -1, -1, 16, "H");
    check("H_frame_done", 32'(n_fd), 32'd4);
    check("H_sync_err", 32'(n_se), 32'd1);
    frame(VT, 0, 1'b0, -1, -1, -1, 0, "I");
    check("I_sync_err", 32'(n_se), 32'd2);
    check("I_frame_done", 32'(n_fd), 32'd4);
    check("I_locked", 32'(locked), 32'd0);
    frame(VT, 0, 1'b0, -1, -1, -1, 0, "J");

    // Reset in the middle of a locked frame's active region
    frame(VT, 1, 1'b1, -1, 8, -1, 4, "K");
    check("K_locked", 32'(locked), 32'd0);
    frame(VT, 1, 1'b0, -1, -1, -1, 0, "L");
    check("L_locked", 32'(locked), 32'd0);

    // pix_en held low for 100 clocks right after a sample point
    frame(VT, 1, 1'b1, -1, -1, 6, 16, "M");
    check("M_locked", 32'(locked), 32'd1);
    frame(VT, 2, 1'b1, -1, -1, -1, 16, "N");
    check("N_frame_done", 32'(n_fd), 32'd5);
    check("N_sync_err", 32'(n_se), 32'd2);
    check("N_locked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
